// File: rtl/round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : round_sequencer
//  Description : Plays one round of the memory game on the LEDs, then checks
//                the player's button presses against the stored sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module round_sequencer #(
   parameter int MAX_LEN     = 16,
   parameter int IDX_W       = 4,
   parameter int TICK_CYC    = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_round,
   input  logic [IDX_W:0]   round_len,
   input  logic [1:0]       speed,
   output logic             mem_rd,
   output logic [IDX_W-1:0] mem_addr,
   input  logic [1:0]       mem_data,
   output logic             led_en,
   output logic [1:0]       led_color,
   input  logic             btn_valid,
   input  logic [1:0]       btn_code,
   output logic             busy,
   output logic             round_pass,
   output logic             round_fail
);

   localparam int TMR_W = $clog2(4 * TICK_CYC + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

   localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(TICK_CYC - 1);
   localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [IDX_W:0]   LEN_MAX    = (IDX_W+1)'(MAX_LEN);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_FETCH    = 4'd1;
   localparam logic [3:0] S_LATCH    = 4'd2;
   localparam logic [3:0] S_SHOW     = 4'd3;
   localparam logic [3:0] S_GAP      = 4'd4;
   localparam logic [3:0] S_READ_EXP = 4'd5;
   localparam logic [3:0] S_LOAD_EXP = 4'd6;
   localparam logic [3:0] S_LISTEN   = 4'd7;
   localparam logic [3:0] S_PASS     = 4'd8;
   localparam logic [3:0] S_FAIL     = 4'd9;

   logic [3:0]       state;
   logic [3:0]       state_nxt;
   logic [IDX_W:0]   len;
   logic [IDX_W:0]   len_clamped;
   logic [1:0]       spd;
   logic [IDX_W-1:0] idx;
   logic [TMR_W-1:0] tmr;
   logic [TMR_W-1:0] on_load;
   logic [TO_W-1:0]  to_cnt;
   logic [1:0]       expected;
   logic             start_ok;
   logic             last_item;
   logic             tmr_done;
   logic             to_expired;
   logic             btn_match;

   assign start_ok    = start_round && (round_len != '0);
   assign len_clamped = (round_len > LEN_MAX) ? LEN_MAX : round_len;
   assign last_item   = ({1'b0, idx} == (len - (IDX_W+1)'(1)));
   assign tmr_done    = (tmr == '0);
   assign to_expired  = (to_cnt == TO_LAST);
   assign btn_match   = (btn_code == expected);
   // Timer is loaded with duration-1 so it reaches zero on the last cycle.
   assign on_load     = TMR_W'((4 - int'(spd)) * TICK_CYC - 1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (start_ok) state_nxt = S_FETCH;
         S_FETCH:    state_nxt = S_LATCH;
         S_LATCH:    state_nxt = S_SHOW;
         S_SHOW:     if (tmr_done) state_nxt = S_GAP;
         S_GAP:      if (tmr_done) state_nxt = last_item ? S_READ_EXP : S_FETCH;
         S_READ_EXP: state_nxt = S_LOAD_EXP;
         S_LOAD_EXP: state_nxt = S_LISTEN;
         S_LISTEN: begin
            // A press on the expiring cycle takes priority over the timeout.
            if (btn_valid) begin
               if (!btn_match)     state_nxt = S_FAIL;
               else if (last_item) state_nxt = S_PASS;
               else                state_nxt = S_READ_EXP;
            end else if (to_expired) begin
               state_nxt = S_FAIL;
            end
         end
         S_PASS:     state_nxt = S_IDLE;
         S_FAIL:     state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         idx       <= '0;
         len       <= '0;
         spd       <= '0;
         tmr       <= '0;
         to_cnt    <= '0;
         expected  <= '0;
         led_color <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  idx <= '0;
                  len <= len_clamped;
                  spd <= speed;
               end
            end
            S_LATCH: begin
               led_color <= mem_data;
               tmr       <= on_load;
            end
            S_SHOW: begin
               tmr <= tmr_done ? GAP_LOAD : (tmr - TMR_W'(1));
            end
            S_GAP: begin
               if (!tmr_done) begin
                  tmr <= tmr - TMR_W'(1);
               end else if (last_item) begin
                  idx <= '0;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            S_LOAD_EXP: begin
               expected <= mem_data;
               to_cnt   <= '0;
            end
            S_LISTEN: begin
               if (btn_valid && btn_match && !last_item) idx <= idx + IDX_W'(1);
               if (!to_expired) to_cnt <= to_cnt + TO_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      mem_rd     = (state == S_FETCH) || (state == S_READ_EXP);
      mem_addr   = idx;
      led_en     = (state == S_SHOW);
      busy       = (state != S_IDLE) && (state != S_PASS) && (state != S_FAIL);
      round_pass = (state == S_PASS);
      round_fail = (state == S_FAIL);
   end

endmodule
`default_nettype wire
